// File: rtl/random_range_generator.sv
// Galois-LFSR random draw with rejection sampling into [0, LIMIT).
// Optional rejected-candidate counter is enabled by defining RANDOM_RANGE_STATS_EN.
module random_range_generator #(
  parameter int           N         = 16,
  parameter logic [N-1:0] TAPS      = 16'hB400,
  parameter int           MAX_TRIES = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [N-1:0] SEED,
  input  logic         SEED_LOAD,
  input  logic         REQ,
  input  logic [N-1:0] LIMIT,
  output logic         READY,
  output logic         VALID,
  output logic [N-1:0] RESULT,
  output logic [N-1:0] RAW,
  output logic [15:0]  REJECT_COUNT
);

  localparam int TW = $clog2(MAX_TRIES + 1);

  typedef enum logic {IDLE, DRAW} state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    s, l, m;
  logic [TW-1:0]   tries;
  logic [N-1:0]    seed_fix, s_adv, lm1, m_new, cand, res_nxt;
  logic            accept, last_try, capture, done, rej;

  assign seed_fix = (SEED == '0) ? '1 : SEED;
  assign s_adv    = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);

  // Mask of ones from bit 0 up to the top set bit of LIMIT-1 (prefix-OR downward).
  assign lm1 = LIMIT - N'(1);
  always_comb begin
    m_new = lm1;
    for (int i = N - 2; i >= 0; i--) m_new[i] = m_new[i] | m_new[i+1];
  end

  assign cand     = s & m;
  assign accept   = (l == '0) || (cand < l);
  assign last_try = (tries == TW'(MAX_TRIES - 1));
  // Forced result after the final rejection: cand < 2L so cand-L < L.
  assign res_nxt  = accept ? cand : (cand - l);
  assign rej      = (state == DRAW) && !accept;
  assign READY    = (state == IDLE);
  assign RAW      = s;

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (REQ) begin
        capture   = 1'b1;
        state_nxt = DRAW;
      end
      DRAW: if (accept || last_try) begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s      <= seed_fix;
      VALID  <= 1'b0;
      RESULT <= '0;
      l      <= '0;
      m      <= '0;
      tries  <= '0;
    end else begin
      s     <= SEED_LOAD ? seed_fix : s_adv;
      VALID <= done;
      if (done) RESULT <= res_nxt;
      if (capture) begin
        l     <= LIMIT;
        m     <= m_new;
        tries <= '0;
      end else if (rej) begin
        tries <= tries + TW'(1);
      end
    end
  end

`ifdef RANDOM_RANGE_STATS_EN
  logic [15:0] rcnt;
  always_ff @(posedge CLK) begin
    if (RESET)                         rcnt <= '0;
    else if (rej && rcnt != 16'hFFFF)  rcnt <= rcnt + 16'd1;
  end
  assign REJECT_COUNT = rcnt;
`else
  assign REJECT_COUNT = 16'h0000;
`endif

endmodule

// File: tb/tb_random_range_generator.sv
// Randomized self-checking bench for random_range_generator against a draw-level model.
module tb_random_range_generator;
  logic        CLK = 1'b0;
  logic        RESET = 1'b0, SEED_LOAD = 1'b0, REQ = 1'b0;
  logic [15:0] SEED = 16'h0001, LIMIT = 16'h0000;
  logic        ready, valid, ready1, valid1;
  logic [15:0] result, raw, rcnt, result1, raw1, rcnt1;

  int          total = 0, bad = 0;
  logic [15:0] ms;
  int          exp_rej = 0, exp_rej1 = 0;

  random_range_generator #(.N(16), .TAPS(16'hB400), .MAX_TRIES(4)) dut (
    .CLK(CLK), .RESET(RESET), .SEED(SEED), .SEED_LOAD(SEED_LOAD), .REQ(REQ), .LIMIT(LIMIT),
    .READY(ready), .VALID(valid), .RESULT(result), .RAW(raw), .REJECT_COUNT(rcnt));

  random_range_generator #(.N(16), .TAPS(16'hB400), .MAX_TRIES(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .SEED(SEED), .SEED_LOAD(SEED_LOAD), .REQ(REQ), .LIMIT(LIMIT),
    .READY(ready1), .VALID(valid1), .RESULT(result1), .RAW(raw1), .REJECT_COUNT(rcnt1));

  always #5 CLK = ~CLK;

  function automatic logic [15:0] adv(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic logic [15:0] fix(input logic [15:0] s);
    return (s == 16'h0) ? 16'hFFFF : s;
  endfunction

  // Smallest all-ones value covering L-1.
  function automatic logic [15:0] mask_for(input logic [15:0] L);
    logic [15:0] mm, lm;
    mm = 16'h0;
    lm = L - 16'd1;
    while (mm < lm) mm = {mm[14:0], 1'b1};
    return mm;
  endfunction

  function automatic logic [15:0] rc_exp(input int e);
`ifdef RANDOM_RANGE_STATS_EN
    return (e > 65535) ? 16'hFFFF : 16'(e);
`else
    return (e < 0) ? 16'h1 : 16'h0;
`endif
  endfunction

  // Walk the candidate sequence: s0 first, then s1, then LFSR successors of s1.
  task automatic predict(input logic [15:0] L, input logic [15:0] s0, input logic [15:0] s1,
                         input int maxt, output logic [15:0] res, output int t, output int rj);
    logic [15:0] s, c, mm;
    mm = mask_for(L);
    s = s0; rj = 0; t = 0; res = 16'h0;
    for (int i = 0; i < maxt; i++) begin
      if (i == 1) s = s1;
      else if (i > 1) s = adv(s);
      c = s & mm;
      if (L == 16'h0 || c < L) begin
        res = c; t = i + 1;
        return;
      end
      rj++;
      if (i == maxt - 1) begin
        res = c - L; t = i + 1;
      end
    end
  endtask

  task automatic step();
    if (RESET || SEED_LOAD) ms = fix(SEED);
    else                    ms = adv(ms);
    @(posedge CLK); #1;
  endtask

  task automatic do_reset(input logic [15:0] sd);
    SEED = sd; RESET = 1'b1; REQ = 1'b0; SEED_LOAD = 1'b0;
    step();
    RESET = 1'b0;
    exp_rej = 0; exp_rej1 = 0;
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!ready && w < 20) begin step(); w++; end
    total++;
    if (!ready) begin bad++; $display("FAIL wait_ready: ready=%0b required 1", ready); end
  endtask

  task automatic test_reset();
    logic [15:0] seq [4];
    seq[0] = 16'hB400; seq[1] = 16'h5A00; seq[2] = 16'h2D00; seq[3] = 16'h1680;
    do_reset(16'h0001);
    total += 6;
    if (raw !== 16'h0001) begin bad++; $display("FAIL reset_raw: got %h required 0001", raw); end
    if (ready !== 1'b1 || ready1 !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b/%b required 1", ready, ready1); end
    if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b required 0", valid); end
    if (result !== 16'h0) begin bad++; $display("FAIL reset_result: got %h required 0000", result); end
    if (rcnt !== 16'h0) begin bad++; $display("FAIL reset_rcnt: got %h required 0000", rcnt); end
    if (raw1 !== raw) begin bad++; $display("FAIL reset_raw1: got %h required %h", raw1, raw); end
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (raw !== seq[i] || raw !== ms) begin bad++; $display("FAIL lfsr_seq[%0d]: got %h required %h", i, raw, seq[i]); end
    end
  endtask

  task automatic test_zero_seed();
    do_reset(16'h0000);
    total++;
    if (raw !== 16'hFFFF) begin bad++; $display("FAIL zero_seed_reset: got %h required FFFF", raw); end
    step(); step(); step();
    SEED = 16'h0000; SEED_LOAD = 1'b1;
    step();
    SEED_LOAD = 1'b0;
    total++;
    if (raw !== 16'hFFFF) begin bad++; $display("FAIL zero_seed_load: got %h required FFFF", raw); end
    step();
    total++;
    if (raw !== ms) begin bad++; $display("FAIL after_load: got %h required %h", raw, ms); end
  endtask

  task automatic test_known_draw();
    int vc = -1, vc1 = -1;
    logic [15:0] r = 16'h0, r1 = 16'h0;
    do_reset(16'h000E);
    REQ = 1'b1; LIMIT = 16'd5;
    step();
    REQ = 1'b0; LIMIT = 16'd9;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      if (valid && vc < 0) begin vc = cyc; r = result; end
      if (valid1 && vc1 < 0) begin vc1 = cyc; r1 = result1; end
      step();
    end
    exp_rej += 1; exp_rej1 += 1;
    total += 6;
    if (vc != 3) begin bad++; $display("FAIL known_lat4: got cycle %0d required 3", vc); end
    if (r !== 16'd3) begin bad++; $display("FAIL known_res4: got %0d required 3", r); end
    if (vc1 != 2) begin bad++; $display("FAIL known_lat1: got cycle %0d required 2", vc1); end
    if (r1 !== 16'd2) begin bad++; $display("FAIL known_res1: got %0d required 2", r1); end
    if (rcnt !== rc_exp(exp_rej)) begin bad++; $display("FAIL known_rcnt4: got %0d required %0d", rcnt, rc_exp(exp_rej)); end
    if (rcnt1 !== rc_exp(exp_rej1)) begin bad++; $display("FAIL known_rcnt1: got %0d required %0d", rcnt1, rc_exp(exp_rej1)); end
  endtask

  task automatic do_draw(input logic [15:0] L, input logic noise, input logic sl);
    logic [15:0] res, s1, raw_draw;
    int t, rj, n;
    logic got;
    wait_ready();
    REQ = 1'b1; LIMIT = L;
    step();
    REQ = noise; LIMIT = 16'($urandom);
    raw_draw = raw;
    if (sl) begin SEED = 16'($urandom); SEED_LOAD = 1'b1; s1 = fix(SEED); end
    else s1 = adv(ms);
    predict(L, ms, s1, 4, res, t, rj);
    exp_rej += rj;
    n = 0; got = 1'b0;
    while (n < 8 && !got) begin
      if (valid) got = 1'b1;
      else begin step(); SEED_LOAD = 1'b0; n++; end
    end
    REQ = 1'b0;
    total += 4;
    if (!got || n != t) begin bad++; $display("FAIL draw_latency L=%h: got %0d required %0d", L, n, t); end
    if (result !== res) begin bad++; $display("FAIL draw_result L=%h: got %h required %h", L, result, res); end
    if (ready !== 1'b1) begin bad++; $display("FAIL draw_ready: got %b required 1", ready); end
    if (rcnt !== rc_exp(exp_rej)) begin bad++; $display("FAIL draw_rcnt: got %0d required %0d", rcnt, rc_exp(exp_rej)); end
    if (L == 16'h0 && !sl) begin
      total++;
      if (result !== raw_draw) begin bad++; $display("FAIL draw_full_range: got %h required %h", result, raw_draw); end
    end
    step();
    total += 2;
    if (valid !== 1'b0) begin bad++; $display("FAIL valid_pulse: got %b required 0", valid); end
    if (result !== res) begin bad++; $display("FAIL result_hold: got %h required %h", result, res); end
  endtask

  task automatic test_limits();
    do_draw(16'd1, 1'b0, 1'b0);
    total++;
    if (result !== 16'h0) begin bad++; $display("FAIL limit_one: got %h required 0000", result); end
    do_draw(16'd0, 1'b1, 1'b0);
    do_draw(16'hFFFF, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] L;
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0: L = 16'd0;
        1: L = 16'd1;
        2: L = 16'($urandom_range(2, 20));
        default: L = 16'($urandom);
      endcase
      do_draw(L, 1'($urandom_range(0, 1)), (it % 5) == 2);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] r;
    wait_ready();
    REQ = 1'b1; LIMIT = 16'h0;
    step();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      r = raw;
      total++;
      if (valid !== 1'b0 || ready !== 1'b0) begin bad++; $display("FAIL b2b_draw[%0d]: valid=%b ready=%b required 0/0", i, valid, ready); end
      step();
      total += 2;
      if (valid !== 1'b1 || ready !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d]: valid=%b ready=%b required 1/1", i, valid, ready); end
      if (result !== r) begin bad++; $display("FAIL b2b_result[%0d]: got %h required %h", i, result, r); end
    end
    REQ = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_draw();
    wait_ready();
    REQ = 1'b1; LIMIT = 16'h0;
    step();
    REQ = 1'b0; RESET = 1'b1; SEED = 16'($urandom);
    step();
    RESET = 1'b0; exp_rej = 0;
    total += 5;
    if (valid !== 1'b0) begin bad++; $display("FAIL abort_valid: got %b required 0", valid); end
    if (result !== 16'h0) begin bad++; $display("FAIL abort_result: got %h required 0000", result); end
    if (ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b required 1", ready); end
    if (raw !== ms) begin bad++; $display("FAIL abort_raw: got %h required %h", raw, ms); end
    if (rcnt !== 16'h0) begin bad++; $display("FAIL abort_rcnt: got %h required 0000", rcnt); end
  endtask

  initial begin
    test_reset();
    test_zero_seed();
    test_known_draw();
    do_reset(16'hACE1);
    test_limits();
    test_random();
    test_back_to_back();
    test_reset_mid_draw();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
